// File: rtl/ff_bank.sv
// ff_bank: WIDTH-bit register bank that acts as SR, JK, D or T flip-flops,
// chosen per clock edge by the mode input. The SR 11 input combination is
// treated as forbidden: the bit holds its state and raises a sticky error
// flag.
//
// Build option: define FF_BANK_ERR_CNT_EN to add the CNT_W parameter, the
// err_cnt output, and a saturating counter of edges that saw at least one
// forbidden bit. Without the macro, neither the port nor the counter exists.
//
// This is a datapath block with no handshake. Every input is sampled on the
// rising edge of clk. q, err and err_cnt update one edge later. qbar is ~q.
module ff_bank #(
    parameter int WIDTH = 4,
`ifdef FF_BANK_ERR_CNT_EN
    parameter int CNT_W = 8,
`endif
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] err
`ifdef FF_BANK_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] sr_set;
    logic [WIDTH-1:0] sr_clr;
    logic [WIDTH-1:0] forbidden;
    logic [WIDTH-1:0] err_next;

    // SR decode. 10 sets and 01 clears. 11 matches neither term, so the bit holds.
    assign sr_set = a & ~b;
    assign sr_clr = ~a & b;

    // A forbidden event needs SR mode and an enabled edge. A gated edge never flags.
    assign forbidden = (en && (mode == MODE_SR)) ? (a & b) : '0;

    // Per-bit next state for the selected flip-flop type.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_SR: q_next = (q | sr_set) & ~sr_clr;
            MODE_JK: q_next = (a & ~q) | (~b & q);
            MODE_D:  q_next = a;
            MODE_T:  q_next = q ^ a;
            default: q_next = q;
        endcase
    end

    // clr_err wipes the old flags. A new event on the same edge is ORed in afterwards, so the new event wins.
    always_comb begin
        err_next = clr_err ? '0 : err;
        err_next = err_next | forbidden;
    end

    // State register. Reset has priority. en gates updates of q only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

    // Sticky error flags. These can clear even while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            err <= err_next;
        end
    end

    // The complementary output comes straight from the register. No input reaches it combinationally.
    assign qbar = ~q;

`ifdef FF_BANK_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             any_forbidden;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    // The counter advances once per qualifying edge, however many bits are forbidden.
    assign any_forbidden = |forbidden;

    // Apply the clear first, then count. A clear plus a new event therefore gives exactly 1.
    always_comb begin
        cnt_base = clr_err ? '0 : err_cnt;
        cnt_next = cnt_base;
        if (any_forbidden && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + 1'b1;
        end
    end

    // Saturating forbidden-event counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: table-driven checks for ff_bank (WIDTH=4, RST_VAL=1010 and,
// when FF_BANK_ERR_CNT_EN is defined, CNT_W=2). Each applied vector pushes
// its expected {q, err, err_cnt} onto a queue. The queue is popped and
// compared #1 after the rising edge.
module tb_ff_bank;

    localparam int W = 4 + 4 + 2;

    localparam logic [1:0] SR = 2'b00;
    localparam logic [1:0] JK = 2'b01;
    localparam logic [1:0] DM = 2'b10;
    localparam logic [1:0] TM = 2'b11;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
        logic       clr;
        logic [3:0] eq;
        logic [3:0] ee;
        logic [1:0] ec;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr_err;
    logic [3:0] q;
    logic [3:0] qbar;
    logic [3:0] err;
`ifdef FF_BANK_ERR_CNT_EN
    logic [1:0] err_cnt;
`endif

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    // Independent reference state for the random phase.
    logic [3:0] m_q;
    logic [3:0] m_err;
    logic [1:0] m_cnt;

    ff_bank #(
        .WIDTH(4),
`ifdef FF_BANK_ERR_CNT_EN
        .CNT_W(2),
`endif
        .RST_VAL(4'b1010)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode(mode),
        .a(a),
        .b(b),
        .clr_err(clr_err),
        .q(q),
        .qbar(qbar),
        .err(err)
`ifdef FF_BANK_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [3:0] va, input logic [3:0] vb, input logic c,
                                input logic [3:0] xq, input logic [3:0] xe, input logic [1:0] xc);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c;
        v.eq = xq; v.ee = xe; v.ec = xc;
        return v;
    endfunction

    // Compare the DUT outputs against the oldest expectation in the queue.
    task automatic check(input string name);
        logic [W-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        if (q !== e[9:6]) begin
            miscompares++;
            $display("FAIL %s q: got %b want %b", name, q, e[9:6]);
        end
        if (qbar !== ~e[9:6]) begin
            miscompares++;
            $display("FAIL %s qbar: got %b want %b", name, qbar, ~e[9:6]);
        end
        if (err !== e[5:2]) begin
            miscompares++;
            $display("FAIL %s err: got %b want %b", name, err, e[5:2]);
        end
`ifdef FF_BANK_ERR_CNT_EN
        if (err_cnt !== e[1:0]) begin
            miscompares++;
            $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, e[1:0]);
        end
`endif
    endtask

    // Drive one vector on the falling edge, record its expectation, and check after the rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst_n = v.rst_n; en = v.en; mode = v.mode; a = v.a; b = v.b; clr_err = v.clr;
        exp_q.push_back({v.eq, v.ee, v.ec});
        @(posedge clk);
        #1;
        check(name);
    endtask

    // Reference behaviour, written bit by bit from the flip-flop truth tables.
    task automatic model_step(inout vec_t v);
        logic any_f;
        if (!v.rst_n) begin
            m_q = 4'b1010; m_err = 4'b0000; m_cnt = 2'd0;
        end else begin
            any_f = 1'b0;
            if (v.clr) begin
                m_err = 4'b0000; m_cnt = 2'd0;
            end
            for (int i = 0; i < 4; i++) begin
                if (v.en) begin
                    case (v.mode)
                        SR: begin
                            if (v.a[i] && !v.b[i]) m_q[i] = 1'b1;
                            else if (!v.a[i] && v.b[i]) m_q[i] = 1'b0;
                            else if (v.a[i] && v.b[i]) begin
                                m_err[i] = 1'b1;
                                any_f = 1'b1;
                            end
                        end
                        JK: begin
                            if (v.a[i] && v.b[i]) m_q[i] = ~m_q[i];
                            else if (v.a[i]) m_q[i] = 1'b1;
                            else if (v.b[i]) m_q[i] = 1'b0;
                        end
                        DM: m_q[i] = v.a[i];
                        default: if (v.a[i]) m_q[i] = ~m_q[i];
                    endcase
                end
            end
            if (any_f && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
        v.eq = m_q; v.ee = m_err; v.ec = m_cnt;
    endtask

    // Stimulus and report.
    initial begin
        vec_t v;
        rst_n = 1'b0; en = 1'b0; mode = SR; a = '0; b = '0; clr_err = 1'b0;

        //            rst en mode a        b        clr  q        err      cnt
        tbl.push_back(mk(0, 1, TM, 4'b1111, 4'b1111, 0, 4'b1010, 4'b0000, 2'd0)); // reset, busy inputs
        tbl.push_back(mk(0, 0, SR, 4'b1111, 4'b1111, 1, 4'b1010, 4'b0000, 2'd0)); // reset beats forbidden
        tbl.push_back(mk(1, 1, SR, 4'b0000, 4'b0000, 0, 4'b1010, 4'b0000, 2'd0)); // release, hold
        tbl.push_back(mk(1, 1, DM, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0)); // load 0000
        tbl.push_back(mk(1, 1, SR, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 2'd0)); // SR set
        tbl.push_back(mk(1, 1, SR, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0000, 2'd0)); // SR hold
        tbl.push_back(mk(1, 1, SR, 4'b0000, 4'b0001, 0, 4'b0000, 4'b0000, 2'd0)); // SR clear
        tbl.push_back(mk(1, 1, SR, 4'b0011, 4'b0001, 0, 4'b0010, 4'b0001, 2'd1)); // SR forbidden bit0
        tbl.push_back(mk(1, 1, DM, 4'b0101, 4'b0000, 0, 4'b0101, 4'b0001, 2'd1)); // load 0101
        tbl.push_back(mk(1, 1, JK, 4'b1111, 4'b1111, 0, 4'b1010, 4'b0001, 2'd1)); // JK toggle
        tbl.push_back(mk(1, 1, TM, 4'b0011, 4'b0000, 0, 4'b1001, 4'b0001, 2'd1)); // T toggle
        tbl.push_back(mk(1, 0, TM, 4'b1111, 4'b0000, 0, 4'b1001, 4'b0001, 2'd1)); // en=0 holds
        tbl.push_back(mk(1, 1, DM, 4'b0110, 4'b0000, 0, 4'b0110, 4'b0001, 2'd1)); // D
        tbl.push_back(mk(1, 1, SR, 4'b0000, 4'b0000, 0, 4'b0110, 4'b0001, 2'd1)); // mode change keeps q
        tbl.push_back(mk(1, 1, SR, 4'b1000, 4'b1000, 1, 4'b0110, 4'b1000, 2'd1)); // clr + new event
        tbl.push_back(mk(1, 1, SR, 4'b0000, 4'b0000, 1, 4'b0110, 4'b0000, 2'd0)); // clr
        tbl.push_back(mk(1, 0, SR, 4'b1111, 4'b1111, 0, 4'b0110, 4'b0000, 2'd0)); // gated forbidden
        tbl.push_back(mk(1, 1, SR, 4'b0100, 4'b0100, 0, 4'b0110, 4'b0100, 2'd1)); // forbidden bit2
        tbl.push_back(mk(1, 0, SR, 4'b0000, 4'b0000, 1, 4'b0110, 4'b0000, 2'd0)); // clr while en=0
        tbl.push_back(mk(1, 1, JK, 4'b0001, 4'b0001, 0, 4'b0111, 4'b0000, 2'd0)); // JK 11 is no error
        tbl.push_back(mk(0, 1, DM, 4'b0000, 4'b0000, 0, 4'b1010, 4'b0000, 2'd0)); // mid-run reset
        tbl.push_back(mk(1, 1, SR, 4'b1111, 4'b1111, 0, 4'b1010, 4'b1111, 2'd1)); // 4 bits, count 1
        tbl.push_back(mk(1, 1, SR, 4'b0011, 4'b0011, 0, 4'b1010, 4'b1111, 2'd2)); // count 2

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Saturation: clear, then five forbidden edges in a row.
        apply(mk(1, 1, SR, 4'b0000, 4'b0000, 1, 4'b1010, 4'b0000, 2'd0), "sat_clr");
        for (int k = 0; k < 5; k++) begin
            logic [1:0] xc;
            xc = (k < 3) ? 2'(k + 1) : 2'd3;
            apply(mk(1, 1, SR, 4'b0001, 4'b0001, 0, 4'b1010, 4'b0001, xc),
                  $sformatf("sat%0d", k));
        end
        apply(mk(1, 1, SR, 4'b0010, 4'b0010, 1, 4'b1010, 4'b0010, 2'd1), "sat_clr_new");

        // Random phase, checked against the reference model. It starts from a reset.
        v = mk(0, 1, SR, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2'd0);
        model_step(v);
        apply(v, "rnd_rst");
        for (int k = 0; k < 60; k++) begin
            v.rst_n = ($urandom_range(0, 19) != 0);
            v.en    = ($urandom_range(0, 4) != 0);
            v.mode  = 2'($urandom_range(0, 3));
            v.a     = 4'($urandom_range(0, 15));
            v.b     = 4'($urandom_range(0, 15));
            v.clr   = ($urandom_range(0, 7) == 0);
            model_step(v);
            apply(v, $sformatf("rnd%0d", k));
        end

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
